// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot/run/halt control, prioritised redirects,
// valid/ready fetch handshake and a circular return-address stack.
module pc_sequencer #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              INST_BYTES   = 4,
   parameter int              RAS_DEPTH    = 4
) (
   input  logic            clk,
   input  logic            reset,
   output logic            fetch_valid,
   input  logic            fetch_ready,
   output logic [XLEN-1:0] pc,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_offset,
   input  logic            jump,
   input  logic [XLEN-1:0] jump_target,
   input  logic            jalr,
   input  logic [XLEN-1:0] reg_target,
   input  logic            call,
   input  logic            ret,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_vector,
   input  logic            halt,
   output logic            misaligned,
   output logic            ras_underflow
);

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   localparam int              PW       = $clog2(RAS_DEPTH);
   localparam logic [XLEN-1:0] STEP     = XLEN'(INST_BYTES);
   localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INST_BYTES - 1);
   localparam logic [PW:0]     RAS_FULL = (PW + 1)'(RAS_DEPTH);

   logic [1:0]      state_reg, state_next;
   logic [XLEN-1:0] pc_reg, pc_next;
   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] target;
   logic            redirect, advance;
   logic            misaligned_reg, misaligned_next;
   logic            underflow_reg, underflow_next;

   logic [XLEN-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]   ras_top_reg, ras_top_next;
   logic [PW:0]     ras_count_reg, ras_count_next;
   logic            ras_push, ras_pop, ras_clear;
   logic            ras_wr_en;
   logic [PW-1:0]   ras_wr_addr;

   assign seq_pc = pc_reg + STEP;

   always_comb begin
      state_next     = state_reg;
      target         = pc_reg;
      redirect       = 1'b0;
      advance        = 1'b0;
      underflow_next = 1'b0;
      ras_push       = 1'b0;
      ras_pop        = 1'b0;
      ras_clear      = 1'b0;
      case (state_reg)
         ST_BOOT: state_next = ST_RUN;
         ST_RUN: begin
            if (trap_valid) begin
               redirect  = 1'b1;
               target    = trap_vector;
               ras_clear = 1'b1;
            end else if (halt) begin
               state_next = ST_HALT;
            end else if (!stall) begin
               ras_push = call & (jump | jalr);
               if (ret) begin
                  redirect = 1'b1;
                  if (ras_count_reg != '0) begin
                     target  = ras_mem[ras_top_reg];
                     ras_pop = 1'b1;
                  end else begin
                     target         = reg_target;
                     underflow_next = 1'b1;
                  end
               end else if (jalr) begin
                  redirect = 1'b1;
                  target   = reg_target;
               end else if (jump) begin
                  redirect = 1'b1;
                  target   = jump_target;
               end else if (branch_taken) begin
                  redirect = 1'b1;
                  target   = seq_pc + branch_offset;
               end else if (fetch_ready) begin
                  advance = 1'b1;
               end
            end
         end
         ST_HALT: begin
            if (trap_valid) begin
               state_next = ST_RUN;
               redirect   = 1'b1;
               target     = trap_vector;
               ras_clear  = 1'b1;
            end
         end
         default: state_next = ST_BOOT;
      endcase

      if (redirect)
         pc_next = target & ~LOW_MASK;
      else if (advance)
         pc_next = seq_pc;
      else
         pc_next = pc_reg;
      misaligned_next = redirect & (|(target & LOW_MASK));
   end

   // Pop-plus-push rewrites the top in place so the depth is unchanged.
   always_comb begin
      ras_top_next   = ras_top_reg;
      ras_count_next = ras_count_reg;
      ras_wr_en      = 1'b0;
      ras_wr_addr    = ras_top_reg;
      if (ras_clear) begin
         ras_count_next = '0;
      end else if (ras_pop && ras_push) begin
         ras_wr_en = 1'b1;
      end else if (ras_pop) begin
         ras_top_next   = ras_top_reg - PW'(1);
         ras_count_next = ras_count_reg - (PW + 1)'(1);
      end else if (ras_push) begin
         ras_top_next = ras_top_reg + PW'(1);
         ras_wr_addr  = ras_top_reg + PW'(1);
         ras_wr_en    = 1'b1;
         if (ras_count_reg != RAS_FULL)
            ras_count_next = ras_count_reg + (PW + 1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_BOOT;
         pc_reg         <= RESET_VECTOR;
         ras_top_reg    <= '0;
         ras_count_reg  <= '0;
         misaligned_reg <= 1'b0;
         underflow_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         pc_reg         <= pc_next;
         ras_top_reg    <= ras_top_next;
         ras_count_reg  <= ras_count_next;
         misaligned_reg <= misaligned_next;
         underflow_reg  <= underflow_next;
      end
   end

   // Stack contents need no reset: entries are only read while count is nonzero.
   always_ff @(posedge clk) begin
      if (ras_wr_en)
         ras_mem[ras_wr_addr] <= seq_pc;
   end

   assign fetch_valid   = (state_reg == ST_RUN);
   assign pc            = pc_reg;
   assign misaligned    = misaligned_reg;
   assign ras_underflow = underflow_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Vector-table bench for pc_sequencer: each record drives one cycle and its
// expected post-edge outputs travel through a scoreboard queue.
module tb_pc_sequencer;

   localparam logic [9:0] RST = 10'h200, RDY = 10'h100, STL = 10'h080, BR  = 10'h040;
   localparam logic [9:0] JMP = 10'h020, JLR = 10'h010, CAL = 10'h008, RET = 10'h004;
   localparam logic [9:0] TRP = 10'h002, HLT = 10'h001, IDLE = 10'h000;

   typedef struct {
      string       name;
      logic [9:0]  ctl;
      logic [31:0] a;
      logic        fv;
      logic [31:0] pc;
      logic        mis;
      logic        uf;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, fetch_valid, fetch_ready, stall, branch_taken, jump, jalr;
   logic        call, ret, trap_valid, halt, misaligned, ras_underflow;
   logic [31:0] pc, branch_offset, jump_target, reg_target, trap_vector;

   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t tbl[$];
   vec_t exp_q[$];

   always #5 clk = ~clk;

   pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h100), .INST_BYTES(4), .RAS_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
      .pc(pc), .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
      .jump(jump), .jump_target(jump_target), .jalr(jalr), .reg_target(reg_target),
      .call(call), .ret(ret), .trap_valid(trap_valid), .trap_vector(trap_vector),
      .halt(halt), .misaligned(misaligned), .ras_underflow(ras_underflow)
   );

   function automatic vec_t mk(string n, logic [9:0] c, logic [31:0] a, logic fv,
                               logic [31:0] epc, logic mis, logic uf);
      vec_t v;
      v.name = n; v.ctl = c; v.a = a; v.fv = fv; v.pc = epc; v.mis = mis; v.uf = uf;
      return v;
   endfunction

   task automatic chk(string n, logic [31:0] act, logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", n, act, req);
      end
   endtask

   task automatic step(vec_t v);
      vec_t e;
      @(negedge clk);
      {reset, fetch_ready, stall, branch_taken, jump, jalr, call, ret, trap_valid, halt} = v.ctl;
      branch_offset = v.a; jump_target = v.a; reg_target = v.a; trap_vector = v.a;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk({e.name, ".fetch_valid"},   {31'b0, fetch_valid},   {31'b0, e.fv});
      chk({e.name, ".pc"},            pc,                     e.pc);
      chk({e.name, ".misaligned"},    {31'b0, misaligned},    {31'b0, e.mis});
      chk({e.name, ".ras_underflow"}, {31'b0, ras_underflow}, {31'b0, e.uf});
      $display("step %-12s ctl=%h a=%h -> fv=%b pc=%h mis=%b uf=%b",
               e.name, e.ctl, e.a, fetch_valid, pc, misaligned, ras_underflow);
   endtask

   initial begin
      {reset, fetch_ready, stall, branch_taken, jump, jalr, call, ret, trap_valid, halt} = RST;
      branch_offset = '0; jump_target = '0; reg_target = '0; trap_vector = '0;

      // boot, sequential fetch, handshake hold
      tbl.push_back(mk("reset",     RST | RDY,       32'h0,        0, 32'h100,      0, 0));
      tbl.push_back(mk("boot",      RDY,             32'h0,        1, 32'h100,      0, 0));
      tbl.push_back(mk("seq1",      RDY,             32'h0,        1, 32'h104,      0, 0));
      tbl.push_back(mk("seq2",      RDY,             32'h0,        1, 32'h108,      0, 0));
      tbl.push_back(mk("notready1", IDLE,            32'h0,        1, 32'h108,      0, 0));
      tbl.push_back(mk("notready2", IDLE,            32'h0,        1, 32'h108,      0, 0));
      // branches and alignment
      tbl.push_back(mk("jmp200",    JMP,             32'h200,      1, 32'h200,      0, 0));
      tbl.push_back(mk("brneg8",    BR,              32'hFFFFFFF8, 1, 32'h1FC,      0, 0));
      tbl.push_back(mk("jmpmis",    JMP | RDY,       32'h1002,     1, 32'h1000,     1, 0));
      tbl.push_back(mk("misclr",    IDLE,            32'h0,        1, 32'h1000,     0, 0));
      // single call / return / underflow
      tbl.push_back(mk("jmp40",     JMP,             32'h40,       1, 32'h40,       0, 0));
      tbl.push_back(mk("call400",   JMP | CAL,       32'h400,      1, 32'h400,      0, 0));
      tbl.push_back(mk("ret44",     RET | RDY,       32'h0,        1, 32'h44,       0, 0));
      tbl.push_back(mk("retuf80",   RET,             32'h80,       1, 32'h80,       0, 1));
      tbl.push_back(mk("ufclr",     IDLE,            32'h0,        1, 32'h80,       0, 0));
      // five calls into a four-deep stack
      tbl.push_back(mk("callA",     JMP | CAL,       32'h1000,     1, 32'h1000,     0, 0));
      tbl.push_back(mk("callB",     JMP | CAL,       32'h2000,     1, 32'h2000,     0, 0));
      tbl.push_back(mk("callC",     JLR | CAL,       32'h3000,     1, 32'h3000,     0, 0));
      tbl.push_back(mk("callD",     JMP | CAL,       32'h4000,     1, 32'h4000,     0, 0));
      tbl.push_back(mk("callE",     JMP | CAL,       32'h5000,     1, 32'h5000,     0, 0));
      tbl.push_back(mk("retE",      RET,             32'h0,        1, 32'h4004,     0, 0));
      tbl.push_back(mk("retD",      RET,             32'h0,        1, 32'h3004,     0, 0));
      tbl.push_back(mk("retC",      RET,             32'h0,        1, 32'h2004,     0, 0));
      tbl.push_back(mk("retB",      RET,             32'h0,        1, 32'h1004,     0, 0));
      tbl.push_back(mk("ret5uf",    RET,             32'h88,       1, 32'h88,       0, 1));
      // ret together with call: top replaced, target from the stack
      tbl.push_back(mk("call600",   JMP | CAL,       32'h600,      1, 32'h600,      0, 0));
      tbl.push_back(mk("retcall",   RET | CAL | JLR, 32'h700,      1, 32'h8C,       0, 0));
      tbl.push_back(mk("retrepl",   RET,             32'h0,        1, 32'h604,      0, 0));
      tbl.push_back(mk("retuf90",   RET,             32'h90,       1, 32'h90,       0, 1));
      // stall, trap over stall, halt
      tbl.push_back(mk("call300",   JMP | CAL,       32'h300,      1, 32'h300,      0, 0));
      tbl.push_back(mk("stalljmp",  STL | JMP | RDY, 32'h500,      1, 32'h300,      0, 0));
      tbl.push_back(mk("stalltrap", STL | JMP | TRP, 32'h8,        1, 32'h8,        0, 0));
      tbl.push_back(mk("rasclear",  RET,             32'hC0,       1, 32'hC0,       0, 1));
      tbl.push_back(mk("halt",      HLT | RDY,       32'h0,        0, 32'hC0,       0, 0));
      tbl.push_back(mk("halted",    RDY,             32'h0,        0, 32'hC0,       0, 0));
      tbl.push_back(mk("haltjmp",   JMP | RDY,       32'h700,      0, 32'hC0,       0, 0));
      tbl.push_back(mk("trapexit",  TRP,             32'h21,       1, 32'h20,       1, 0));
      tbl.push_back(mk("resume",    RDY,             32'h0,        1, 32'h24,       0, 0));
      // top-of-memory wrap
      tbl.push_back(mk("jmptop",    JMP,             32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 0));
      tbl.push_back(mk("wrap",      RDY,             32'h0,        1, 32'h0,        0, 0));

      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i]);

      // reset mid-operation beats ret and trap, and empties the stack
      step(mk("call50",    JMP | CAL,       32'h50,       1, 32'h50,  0, 0));
      step(mk("rstret",    RST | RET | RDY, 32'h0,        0, 32'h100, 0, 0));
      step(mk("rsttrap",   RST | TRP,       32'h8,        0, 32'h100, 0, 0));
      step(mk("reboot",    RDY,             32'h0,        1, 32'h100, 0, 0));
      step(mk("rstrasuf",  RET,             32'h60,       1, 32'h60,  0, 1));

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
